fetch_decode_unit: RTL and testbench

- Control stage directly upstream of the 4-bit accumulator/ALU datapath.
- Holds the program counter and instruction register, and drives the program-ROM address.
- Sequences a FETCH/EXEC cycle and decodes each instruction into the datapath controls: operand nibble, ALU select, operand-buffer enable, output-buffer enable and accumulator enable.
- Latches ALU carry/zero into a flags register and resolves conditional jumps.

---
 rtl/fdu_pkg.sv | 52 +++++
 rtl/fdu_if.sv | 34 +++
 rtl/fdu_decoder.sv | 101 ++++++++++
 rtl/fetch_decode_unit.sv | 129 ++++++++++++
 tb/tb_fetch_decode_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fdu_pkg.sv
// fdu_pkg: shared definitions for the fetch/decode control stage.
//   - opcode constants (upper nibble of an instruction byte)
//   - ALU select constants driven to the accumulator/ALU datapath
//   - sequencer state encoding
//   - ctrl_t: bundle of datapath control outputs produced by the decoder
// Optional feature macro: FDU_HALT_EN (adds the HALT opcode and HALT state).
package fdu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LIT   = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_CMPI  = 4'h3;
    localparam logic [3:0] OP_NANDI = 4'h4;
    localparam logic [3:0] OP_OUT   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_JC    = 4'h9;
    localparam logic [3:0] OP_JNC   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_JNZ   = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_CMP   = 3'b001;
    localparam logic [2:0] ALU_PASSB = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b011;
    localparam logic [2:0] ALU_NAND  = 3'b100;

`ifdef FDU_HALT_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } fdu_state_t;
`else
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } fdu_state_t;
`endif

    typedef struct packed {
        logic [2:0] alu_sel;
        logic       en_b1;
        logic       en_b2;
        logic       en_accu;
        logic       out_valid;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{alu_sel: ALU_PASSA, en_b1: 1'b0, en_b2: 1'b0,
                                    en_accu: 1'b0, out_valid: 1'b0};

endpackage

// File: rtl/fdu_if.sv
// fdu_if: program-ROM bus plus datapath control/status bundle.
//   rom_addr  : PC_W, ROM address (combinational ROM)
//   rom_data  : ROM_W, byte at rom_addr
//   carry_in  : ALU carry, zero_in : ALU zero
//   oprnd     : 4-bit operand nibble to the operand buffer
//   alu_sel, en_b1, en_b2, en_accu : datapath controls
//   out_valid : one-cycle strobe, datapath output valid. There is no
//               back-pressure: the datapath must accept it the cycle it is high.
// master = fetch/decode unit, slave = ROM + datapath side.
interface fdu_if #(
    parameter int PC_W  = 12,
    parameter int ROM_W = 8
);
    logic [PC_W-1:0]  rom_addr;
    logic [ROM_W-1:0] rom_data;
    logic             carry_in;
    logic             zero_in;
    logic [3:0]       oprnd;
    logic [2:0]       alu_sel;
    logic             en_b1;
    logic             en_b2;
    logic             en_accu;
    logic             out_valid;

    modport master (
        output rom_addr, oprnd, alu_sel, en_b1, en_b2, en_accu, out_valid,
        input  rom_data, carry_in, zero_in
    );

    modport slave (
        input  rom_addr, oprnd, alu_sel, en_b1, en_b2, en_accu, out_valid,
        output rom_data, carry_in, zero_in
    );
endinterface

// File: rtl/fdu_decoder.sv
// fdu_decoder: purely combinational instruction decoder.
//   opcode     : IR upper nibble
//   state      : current sequencer state; controls are only active in EXEC
//   flags      : registered {C, Z}
//   ctrl       : datapath controls
//   is_jump    : opcode is a two-byte jump (PC must skip or load the target)
//   jump_taken : jump condition met, PC loads {IR[3:0], second byte}
//   flag_we    : latch {carry_in, zero_in} into flags at the EXEC edge
//   halt_req   : (FDU_HALT_EN only) HALT decoded in EXEC
module fdu_decoder
    import fdu_pkg::*;
(
    input  logic [3:0] opcode,
    input  fdu_state_t state,
    input  logic [1:0] flags,
    output ctrl_t      ctrl,
    output logic       is_jump,
    output logic       jump_taken,
`ifdef FDU_HALT_EN
    output logic       halt_req,
`endif
    output logic       flag_we
);

    logic flag_c;
    logic flag_z;

    assign flag_c = flags[1];
    assign flag_z = flags[0];

    always_comb begin
        ctrl       = CTRL_IDLE;
        is_jump    = 1'b0;
        jump_taken = 1'b0;
        flag_we    = 1'b0;
`ifdef FDU_HALT_EN
        halt_req   = 1'b0;
`endif
        if (state == ST_EXEC) begin
            case (opcode)
                OP_LIT: begin
                    ctrl.alu_sel = ALU_PASSB;
                    ctrl.en_b1   = 1'b1;
                    ctrl.en_accu = 1'b1;
                end
                OP_ADDI: begin
                    ctrl.alu_sel = ALU_ADD;
                    ctrl.en_b1   = 1'b1;
                    ctrl.en_accu = 1'b1;
                    flag_we      = 1'b1;
                end
                OP_CMPI: begin
                    // Compare only sets flags; the accumulator keeps its value.
                    ctrl.alu_sel = ALU_CMP;
                    ctrl.en_b1   = 1'b1;
                    flag_we      = 1'b1;
                end
                OP_NANDI: begin
                    ctrl.alu_sel = ALU_NAND;
                    ctrl.en_b1   = 1'b1;
                    ctrl.en_accu = 1'b1;
                    flag_we      = 1'b1;
                end
                OP_OUT: begin
                    ctrl.alu_sel   = ALU_PASSA;
                    ctrl.en_b2     = 1'b1;
                    ctrl.out_valid = 1'b1;
                end
                OP_JMP: begin
                    is_jump    = 1'b1;
                    jump_taken = 1'b1;
                end
                OP_JC: begin
                    is_jump    = 1'b1;
                    jump_taken = flag_c;
                end
                OP_JNC: begin
                    is_jump    = 1'b1;
                    jump_taken = ~flag_c;
                end
                OP_JZ: begin
                    is_jump    = 1'b1;
                    jump_taken = flag_z;
                end
                OP_JNZ: begin
                    is_jump    = 1'b1;
                    jump_taken = ~flag_z;
                end
`ifdef FDU_HALT_EN
                OP_HALT: begin
                    halt_req = 1'b1;
                end
`endif
                default: begin
                    // NOP and all unassigned opcodes: defaults stand.
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: control stage for the 4-bit accumulator/ALU datapath.
// Holds PC, IR and the {C, Z} flags register, sequences FETCH/EXEC and
// resolves conditional jumps. Every instruction takes exactly two cycles.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   run        : enables a fetch while in FETCH (ignored elsewhere)
//   bus        : fdu_if.master, ROM bus and datapath controls/status
//   phase      : 0 = FETCH, 1 = EXEC (and HALT)
//   flags      : registered {C, Z}
//   state      : sequencer state, for observation
//   halted     : (FDU_HALT_EN only) sequencer stopped by HALT
// Optional feature macro: FDU_HALT_EN.
module fetch_decode_unit
    import fdu_pkg::*;
#(
    parameter int PC_W  = 12,
    parameter int ROM_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    fdu_if.master       bus,
    output logic        phase,
    output logic [1:0]  flags,
`ifdef FDU_HALT_EN
    output logic        halted,
`endif
    output fdu_state_t  state
);

    logic [PC_W-1:0]  pc;
    logic [ROM_W-1:0] ir;
    fdu_state_t       state_next;
    ctrl_t            ctrl;
    logic             is_jump;
    logic             jump_taken;
    logic             flag_we;
`ifdef FDU_HALT_EN
    logic             halt_req;
`endif

    fdu_decoder u_decoder (
        .opcode     (ir[ROM_W-1 -: 4]),
        .state      (state),
        .flags      (flags),
        .ctrl       (ctrl),
        .is_jump    (is_jump),
        .jump_taken (jump_taken),
`ifdef FDU_HALT_EN
        .halt_req   (halt_req),
`endif
        .flag_we    (flag_we)
    );

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (run) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
`ifdef FDU_HALT_EN
                state_next = halt_req ? ST_HALT : ST_FETCH;
`else
                state_next = ST_FETCH;
`endif
            end
`ifdef FDU_HALT_EN
            ST_HALT: begin
                state_next = ST_HALT;
            end
`endif
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // PC, IR and flags. In EXEC the PC already points past the opcode byte,
    // i.e. at a jump's second byte, so rom_data is the low target byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            ir    <= '0;
            flags <= 2'b00;
        end else begin
            if (state == ST_FETCH && run) begin
                ir <= bus.rom_data;
                pc <= pc + PC_W'(1);
            end
            if (state == ST_EXEC) begin
                if (jump_taken) begin
                    pc <= {ir[3:0], bus.rom_data};
                end else if (is_jump) begin
                    pc <= pc + PC_W'(1);
                end
                if (flag_we) begin
                    flags <= {bus.carry_in, bus.zero_in};
                end
            end
        end
    end

`ifdef FDU_HALT_EN
    assign halted = (state == ST_HALT);
`endif

    assign phase         = (state != ST_FETCH);
    assign bus.rom_addr  = pc;
    assign bus.oprnd     = ir[3:0];
    assign bus.alu_sel   = ctrl.alu_sel;
    assign bus.en_b1     = ctrl.en_b1;
    assign bus.en_b2     = ctrl.en_b2;
    assign bus.en_accu   = ctrl.en_accu;
    assign bus.out_valid = ctrl.out_valid;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb_fetch_decode_unit: directed, table-driven bench for fetch_decode_unit.
// The ROM is a bench array read combinationally at rom_addr. Inputs are
// driven and outputs sampled on the falling clock edge.
// Optional feature macro: FDU_HALT_EN (enables the HALT sequence).
module tb_fetch_decode_unit;
    import fdu_pkg::*;

    localparam int PC_W  = 12;
    localparam int ROM_W = 8;

    logic clk;
    logic reset;
    logic run;
    logic carry;
    logic zero;
    logic phase;
    logic [1:0] flags;
    fdu_state_t dbg_state;
`ifdef FDU_HALT_EN
    logic halted;
`endif

    logic [ROM_W-1:0] rom [0:(1<<PC_W)-1];

    int n_checks;
    int n_fail;

    fdu_if #(.PC_W(PC_W), .ROM_W(ROM_W)) bus ();

    assign bus.rom_data = rom[bus.rom_addr];
    assign bus.carry_in = carry;
    assign bus.zero_in  = zero;

    fetch_decode_unit #(.PC_W(PC_W), .ROM_W(ROM_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .bus    (bus),
        .phase  (phase),
        .flags  (flags),
`ifdef FDU_HALT_EN
        .halted (halted),
`endif
        .state  (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic clear_rom();
        for (int a = 0; a < (1 << PC_W); a++) rom[a] = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        carry = 1'b0;
        zero  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_alu"}, 32'(bus.alu_sel), 32'(0));
        check({name, "_ctl"}, {28'd0, bus.en_b1, bus.en_b2, bus.en_accu, bus.out_valid}, 32'(0));
    endtask

    // Single-instruction vectors, each run from reset with flags = 00.
    typedef struct {
        logic [7:0]  instr;
        logic [7:0]  byte2;
        logic        c_in;
        logic        z_in;
        logic [2:0]  alu;
        logic        b1;
        logic        b2;
        logic        accu;
        logic        ov;
        logic [1:0]  exp_flags;
        logic [11:0] exp_pc;
    } vec_t;

    vec_t vecs [0:15];
    int   n_vec;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clear_rom();
        do_reset();

        // Reset state
        check("rst_pc", 32'(bus.rom_addr), 32'h0);
        check("rst_phase", 32'(phase), 32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_FETCH));
        check("rst_oprnd", 32'(bus.oprnd), 32'h0);
        check_idle("rst");

        vecs[0]  = '{8'h17, 8'h00, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 12'h001};
        vecs[1]  = '{8'h2A, 8'h00, 1'b1, 1'b0, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 12'h001};
        vecs[2]  = '{8'h35, 8'h00, 1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 12'h001};
        vecs[3]  = '{8'h4C, 8'h00, 1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 12'h001};
        vecs[4]  = '{8'h50, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 12'h001};
        vecs[5]  = '{8'h00, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 12'h001};
        vecs[6]  = '{8'h63, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 12'h001};
        vecs[7]  = '{8'h7F, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 12'h001};
        vecs[8]  = '{8'hD4, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 12'h001};
        vecs[9]  = '{8'hE2, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 12'h001};
        vecs[10] = '{8'h83, 8'h45, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 12'h345};
        vecs[11] = '{8'h91, 8'h22, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 12'h002};
        vecs[12] = '{8'hA1, 8'h22, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 12'h122};
        vecs[13] = '{8'hB7, 8'h99, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 12'h002};
        vecs[14] = '{8'hC7, 8'h99, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 12'h799};
        n_vec = 15;
`ifndef FDU_HALT_EN
        vecs[15] = '{8'hF3, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 12'h001};
        n_vec = 16;
`endif

        for (int i = 0; i < n_vec; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            clear_rom();
            do_reset();
            rom[0] = vecs[i].instr;
            rom[1] = vecs[i].byte2;
            carry  = vecs[i].c_in;
            zero   = vecs[i].z_in;
            run    = 1'b1;
            @(negedge clk);   // EXEC
            check({tag, "_phase"}, 32'(phase), 32'h1);
            check({tag, "_oprnd"}, 32'(bus.oprnd), 32'(vecs[i].instr[3:0]));
            check({tag, "_alu"}, 32'(bus.alu_sel), 32'(vecs[i].alu));
            check({tag, "_ctl"}, {28'd0, bus.en_b1, bus.en_b2, bus.en_accu, bus.out_valid},
                  {28'd0, vecs[i].b1, vecs[i].b2, vecs[i].accu, vecs[i].ov});
            run = 1'b0;
            @(negedge clk);   // back in FETCH
            check({tag, "_phase2"}, 32'(phase), 32'h0);
            check({tag, "_flags"}, 32'(flags), 32'(vecs[i].exp_flags));
            check({tag, "_pc"}, 32'(bus.rom_addr), 32'(vecs[i].exp_pc));
            check_idle({tag, "_fetch"});
        end

        // Reset asserted mid-EXEC of ADDI at 0x004 (pc = 0x005).
        clear_rom();
        do_reset();
        rom[4] = 8'h21;
        run    = 1'b1;
        carry  = 1'b1;
        zero   = 1'b1;
        repeat (9) @(negedge clk);
        check("mid_pre_pc", 32'(bus.rom_addr), 32'h005);
        check("mid_pre_accu", 32'(bus.en_accu), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("mid_pc", 32'(bus.rom_addr), 32'h0);
        check("mid_phase", 32'(phase), 32'h0);
        check("mid_accu", 32'(bus.en_accu), 32'h0);
        check("mid_flags", 32'(flags), 32'h0);
        @(negedge clk);
        check("mid_flags_hold", 32'(flags), 32'h0);
        reset = 1'b0;

        // LIT 7 then OUT, with a 5-cycle run=0 stall between them.
        clear_rom();
        do_reset();
        rom[0] = 8'h17;
        rom[1] = 8'h50;
        run    = 1'b1;
        @(negedge clk);
        check("lit_alu", 32'(bus.alu_sel), 32'h2);
        check("lit_ctl", {28'd0, bus.en_b1, bus.en_b2, bus.en_accu, bus.out_valid}, 32'b1010);
        check("lit_oprnd", 32'(bus.oprnd), 32'h7);
        @(negedge clk);
        check("lit_pc", 32'(bus.rom_addr), 32'h001);
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_pc", k), 32'(bus.rom_addr), 32'h001);
            check($sformatf("stall%0d_oprnd", k), 32'(bus.oprnd), 32'h7);
            check($sformatf("stall%0d_phase", k), 32'(phase), 32'h0);
            check_idle($sformatf("stall%0d", k));
        end
        run = 1'b1;
        @(negedge clk);
        check("out_ctl", {28'd0, bus.en_b1, bus.en_b2, bus.en_accu, bus.out_valid}, 32'b0101);
        check("out_alu", 32'(bus.alu_sel), 32'h0);
        @(negedge clk);
        check("out_pc", 32'(bus.rom_addr), 32'h002);
        check_idle("out_after");

        // NOP; CMPI 3; JZ 0x1 / 0x23 -- jump sees flags from the CMPI just before.
        for (int r = 0; r < 2; r++) begin
            clear_rom();
            do_reset();
            rom[1] = 8'h33;
            rom[2] = 8'hB1;
            rom[3] = 8'h23;
            carry  = 1'b0;
            zero   = (r == 0);
            run    = 1'b1;
            repeat (4) @(negedge clk);
            check($sformatf("cmpjz%0d_flags", r), 32'(flags), (r == 0) ? 32'h1 : 32'h0);
            repeat (2) @(negedge clk);
            check($sformatf("cmpjz%0d_pc", r), 32'(bus.rom_addr), (r == 0) ? 32'h123 : 32'h004);
        end

        // Wrap-around cases, each reached via JMP 0xFFx from address 0.
        clear_rom();
        do_reset();
        rom[0]      = 8'h8F;
        rom[1]      = 8'hFE;
        rom[12'hFFE] = 8'h80;
        rom[12'hFFF] = 8'h10;
        run = 1'b1;
        repeat (2) @(negedge clk);
        check("wrap_jmp_to_ffe", 32'(bus.rom_addr), 32'hFFE);
        repeat (2) @(negedge clk);
        check("wrap_jmp_pc", 32'(bus.rom_addr), 32'h010);

        clear_rom();
        do_reset();
        rom[0] = 8'h8F;
        rom[1] = 8'hFF;
        run = 1'b1;
        repeat (4) @(negedge clk);
        check("wrap_nop_pc", 32'(bus.rom_addr), 32'h000);

        clear_rom();
        do_reset();
        rom[0]       = 8'h8F;
        rom[1]       = 8'hFE;
        rom[12'hFFE] = 8'h90;   // JC, C = 0 so not taken
        rom[12'hFFF] = 8'h55;
        run = 1'b1;
        repeat (4) @(negedge clk);
        check("wrap_jc_pc", 32'(bus.rom_addr), 32'h000);

`ifdef FDU_HALT_EN
        clear_rom();
        do_reset();
        rom[3] = 8'hF0;
        run = 1'b1;
        repeat (7) @(negedge clk);
        check("halt_pre", 32'(halted), 32'h0);
        @(negedge clk);
        check("halt_set", 32'(halted), 32'h1);
        for (int k = 0; k < 10; k++) begin
            run = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("halt%0d_pc", k), 32'(bus.rom_addr), 32'h004);
            check($sformatf("halt%0d_flag", k), 32'(halted), 32'h1);
            check($sformatf("halt%0d_phase", k), 32'(phase), 32'h1);
            check_idle($sformatf("halt%0d", k));
        end
        do_reset();
        check("halt_rst", 32'(halted), 32'h0);
        check("halt_rst_pc", 32'(bus.rom_addr), 32'h0);
`endif

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
